alarm_mode_controller: RTL

- Mode sequencer for the MM:SS alarm clock datapath.
- Consumes debounced single-cycle button pulses and a 1 Hz strobe.
- Gates and loads the system counter, holds the alarm time, and edits digits under cursor control.
- Drives the digit values and blink mask presented to the segment display mux; detects alarm match and raises the buzzer.

---
 rtl/alarm_mode_controller_pkg.sv | 27 ++
 rtl/bcd_digit_step.sv | 20 ++
 rtl/alarm_mode_controller.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_mode_controller_pkg.sv
// Shared encodings for the MM:SS alarm mode controller: mode values, digit limits,
// cursor digit indices and the packed time record.
package alarm_mode_controller_pkg;

    typedef enum logic [1:0] {
        ModeClock    = 2'b00,
        ModeSetTime  = 2'b01,
        ModeSetAlarm = 2'b10,
        ModeRinging  = 2'b11
    } mode_e;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam logic [1:0] DIG_SEC_UNITS = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS  = 2'd1;
    localparam logic [1:0] DIG_MIN_UNITS = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS  = 2'd3;

    typedef struct packed {
        logic [2:0] min_tens;
        logic [3:0] min_units;
        logic [2:0] sec_tens;
        logic [3:0] sec_units;
    } mmss_t;

endpackage

// File: rtl/bcd_digit_step.sv
// Wrapping increment/decrement of one BCD digit within 0..max.
// No carry or borrow leaves the digit.
module bcd_digit_step (
    input  logic [3:0] i_value,
    input  logic [3:0] i_max,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [3:0] o_value
);

    always_comb begin
        o_value = i_value;
        if (i_inc) begin
            o_value = (i_value >= i_max) ? 4'd0 : i_value + 4'd1;
        end else if (i_dec) begin
            o_value = (i_value == 4'd0) ? i_max : i_value - 4'd1;
        end
    end

endmodule

// File: rtl/alarm_mode_controller.sv
// Mode sequencer for the MM:SS alarm clock: time/alarm editing, counter load and
// gating, display digit/blink selection, alarm match and buzzer with timeouts.
module alarm_mode_controller
    import alarm_mode_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned RING_TICKS    = 60,
    parameter int unsigned TICK_W        = 6
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_btn_center,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic [3:0] i_cur_sec_units,
    input  logic [2:0] i_cur_sec_tens,
    input  logic [3:0] i_cur_min_units,
    input  logic [2:0] i_cur_min_tens,
    output logic       o_count_en,
    output logic       o_load,
    output logic [3:0] o_ld_sec_units,
    output logic [2:0] o_ld_sec_tens,
    output logic [3:0] o_ld_min_units,
    output logic [2:0] o_ld_min_tens,
    output logic [3:0] o_disp_sec_units,
    output logic [2:0] o_disp_sec_tens,
    output logic [3:0] o_disp_min_units,
    output logic [2:0] o_disp_min_tens,
    output logic [3:0] o_blink_mask,
    output logic       o_alarm_armed,
    output logic       o_buzzer,
    output logic [1:0] o_mode
);

    localparam logic [TICK_W-1:0] TimeoutLast = TICK_W'(TIMEOUT_TICKS - 1);
    localparam logic [TICK_W-1:0] RingLast    = TICK_W'(RING_TICKS - 1);

    mode_e             r_mode, w_mode_d;
    logic [1:0]        r_cursor, w_cursor_d;
    mmss_t             r_edit, w_edit_d, w_edit_step;
    mmss_t             r_alarm, w_alarm_d;
    mmss_t             r_ld, w_ld_d;
    mmss_t             r_disp, w_disp_d;
    mmss_t             w_cur;
    logic [TICK_W-1:0] r_tick_cnt, w_tick_d;
    logic              r_armed, w_armed_d;
    logic              r_eq_d, w_eq, w_rise;
    logic              r_load, w_load_d;
    logic              r_count_en, r_buzzer;
    logic [3:0]        r_blink, w_blink_d;
    logic              w_center, w_left, w_right, w_up, w_down, w_any, w_set_d;
    logic [3:0]        w_sel, w_sel_max, w_step;

    assign w_cur = '{min_tens: i_cur_min_tens, min_units: i_cur_min_units,
                     sec_tens: i_cur_sec_tens, sec_units: i_cur_sec_units};

    // Fixed priority: only the highest-ranked coincident button is acted on.
    assign w_center = i_btn_center;
    assign w_left   = i_btn_left  & ~i_btn_center;
    assign w_right  = i_btn_right & ~(i_btn_center | i_btn_left);
    assign w_up     = i_btn_up    & ~(i_btn_center | i_btn_left | i_btn_right);
    assign w_down   = i_btn_down  & ~(i_btn_center | i_btn_left | i_btn_right | i_btn_up);
    assign w_any    = w_center | w_left | w_right | w_up | w_down;

    assign w_eq   = (w_cur == r_alarm);
    assign w_rise = w_eq & ~r_eq_d;

    always_comb begin
        w_sel = {1'b0, r_edit.sec_tens};
        unique case (r_cursor)
            DIG_SEC_UNITS: w_sel = r_edit.sec_units;
            DIG_SEC_TENS:  w_sel = {1'b0, r_edit.sec_tens};
            DIG_MIN_UNITS: w_sel = r_edit.min_units;
            DIG_MIN_TENS:  w_sel = {1'b0, r_edit.min_tens};
        endcase
    end

    assign w_sel_max = r_cursor[0] ? TENS_MAX : UNITS_MAX;

    bcd_digit_step u_step (
        .i_value (w_sel),
        .i_max   (w_sel_max),
        .i_inc   (w_up),
        .i_dec   (w_down),
        .o_value (w_step)
    );

    always_comb begin
        w_edit_step = r_edit;
        unique case (r_cursor)
            DIG_SEC_UNITS: w_edit_step.sec_units = w_step;
            DIG_SEC_TENS:  w_edit_step.sec_tens  = w_step[2:0];
            DIG_MIN_UNITS: w_edit_step.min_units = w_step;
            DIG_MIN_TENS:  w_edit_step.min_tens  = w_step[2:0];
        endcase
    end

    always_comb begin
        w_mode_d   = r_mode;
        w_cursor_d = r_cursor;
        w_edit_d   = r_edit;
        w_alarm_d  = r_alarm;
        w_armed_d  = r_armed;
        w_tick_d   = r_tick_cnt;
        w_load_d   = 1'b0;
        w_ld_d     = r_ld;
        unique case (r_mode)
            ModeClock: begin
                // Held at zero so every mode entry starts a fresh count.
                w_tick_d = '0;
                if (w_rise && r_armed) begin
                    w_mode_d = ModeRinging;
                end else if (w_center) begin
                    w_mode_d   = ModeSetTime;
                    w_edit_d   = w_cur;
                    w_cursor_d = 2'd0;
                end else if (w_right) begin
                    w_mode_d   = ModeSetAlarm;
                    w_edit_d   = r_alarm;
                    w_cursor_d = 2'd0;
                end else if (w_up) begin
                    w_armed_d = ~r_armed;
                end
            end
            ModeSetTime, ModeSetAlarm: begin
                if (w_any) begin
                    w_tick_d = '0;
                end else if (i_tick_1hz) begin
                    if (r_tick_cnt == TimeoutLast) begin
                        w_mode_d = ModeClock;
                        w_tick_d = '0;
                    end else begin
                        w_tick_d = r_tick_cnt + TICK_W'(1);
                    end
                end
                if (w_center) begin
                    w_mode_d = ModeClock;
                    if (r_mode == ModeSetTime) begin
                        w_load_d = 1'b1;
                        w_ld_d   = r_edit;
                    end else begin
                        w_alarm_d = r_edit;
                        w_armed_d = 1'b1;
                    end
                end else if (w_left) begin
                    w_cursor_d = r_cursor + 2'd1;
                end else if (w_right) begin
                    w_cursor_d = r_cursor - 2'd1;
                end else if (w_up || w_down) begin
                    w_edit_d = w_edit_step;
                end
            end
            ModeRinging: begin
                if (w_any) begin
                    w_mode_d = ModeClock;
                    w_tick_d = '0;
                end else if (i_tick_1hz) begin
                    if (r_tick_cnt == RingLast) begin
                        w_mode_d = ModeClock;
                        w_tick_d = '0;
                    end else begin
                        w_tick_d = r_tick_cnt + TICK_W'(1);
                    end
                end
            end
            default: w_mode_d = ModeClock;
        endcase
    end

    assign w_set_d   = (w_mode_d == ModeSetTime) || (w_mode_d == ModeSetAlarm);
    assign w_blink_d = w_set_d ? (4'b0001 << w_cursor_d) : 4'b0000;
    assign w_disp_d  = w_set_d ? w_edit_d : w_cur;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode     <= ModeClock;
            r_cursor   <= 2'd0;
            r_edit     <= '0;
            r_alarm    <= '0;
            r_ld       <= '0;
            r_disp     <= '0;
            r_tick_cnt <= '0;
            r_armed    <= 1'b0;
            r_eq_d     <= 1'b0;
            r_load     <= 1'b0;
            r_count_en <= 1'b1;
            r_buzzer   <= 1'b0;
            r_blink    <= 4'b0000;
        end else begin
            r_mode     <= w_mode_d;
            r_cursor   <= w_cursor_d;
            r_edit     <= w_edit_d;
            r_alarm    <= w_alarm_d;
            r_ld       <= w_ld_d;
            r_disp     <= w_disp_d;
            r_tick_cnt <= w_tick_d;
            r_armed    <= w_armed_d;
            r_eq_d     <= w_eq;
            r_load     <= w_load_d;
            r_count_en <= (w_mode_d != ModeSetTime);
            r_buzzer   <= (w_mode_d == ModeRinging);
            r_blink    <= w_blink_d;
        end
    end

    assign o_mode           = r_mode;
    assign o_count_en       = r_count_en;
    assign o_load           = r_load;
    assign o_buzzer         = r_buzzer;
    assign o_alarm_armed    = r_armed;
    assign o_blink_mask     = r_blink;
    assign o_ld_sec_units   = r_ld.sec_units;
    assign o_ld_sec_tens    = r_ld.sec_tens;
    assign o_ld_min_units   = r_ld.min_units;
    assign o_ld_min_tens    = r_ld.min_tens;
    assign o_disp_sec_units = r_disp.sec_units;
    assign o_disp_sec_tens  = r_disp.sec_tens;
    assign o_disp_min_units = r_disp.min_units;
    assign o_disp_min_tens  = r_disp.min_tens;

endmodule
